// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues single-cycle instruction-memory
// reads, queues {pc, instr} pairs and hands them to decode over valid/ready.
// Redirects flush queued and in-flight fetches.
//
// Optional feature macro: IFU_MISALIGN_TRAP_EN
//   defined   : a redirect to a non-word-aligned target raises sticky fetch_err
//               and parks the unit in TRAP until reset.
//   undefined : redirect_pc[1:0] is ignored (forced to 2'b00), fetch_err is 0.
//
// state | meaning
// ------+-------------------------------------------------------------
// BOOT  | one idle cycle after reset; a redirect here only loads the PC
// RUN   | normal fetching
// TRAP  | misaligned redirect seen; no fetch, no output, until reset
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0004,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            fetch_err_q, fetch_err_d;
    logic [31:0]     fifo_pc_q    [FIFO_DEPTH];
    logic [31:0]     fifo_pc_d    [FIFO_DEPTH];
    logic [31:0]     fifo_instr_q [FIFO_DEPTH];
    logic [31:0]     fifo_instr_d [FIFO_DEPTH];

    logic            pop;
    logic            push;
    logic            misalign;
    logic [31:0]     redirect_target;
    logic [CW:0]     credit_used;

`ifdef IFU_MISALIGN_TRAP_EN
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];
    assign misalign             = 1'b0;
`endif

    assign redirect_target = {redirect_pc[31:2], 2'b00};

    assign if_valid  = (count_q != '0);
    assign if_pc     = if_valid ? fifo_pc_q[rd_ptr_q]    : 32'h0;
    assign if_instr  = if_valid ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign imem_addr = pc_q;
    assign fetch_err = fetch_err_q;

    assign pop  = if_valid && id_ready;
    assign push = inflight_q && !redirect_valid;

    // Entries already queued plus the one on its way back must leave room,
    // so a response can always be written the cycle it arrives.
    assign credit_used = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    assign imem_req    = (state_q == ST_RUN) && !redirect_valid
                         && (credit_used < (CW+1)'(FIFO_DEPTH));

    // Next-state: redirect wins over push, pop and issue.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        fetch_err_d   = fetch_err_q;
        fifo_pc_d     = fifo_pc_q;
        fifo_instr_d  = fifo_instr_q;

        if (redirect_valid) begin
            pc_d     = redirect_target;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            if (misalign) begin
                fetch_err_d = 1'b1;
                state_d     = ST_TRAP;
            end else if (state_q == ST_BOOT) begin
                state_d = ST_RUN;
            end
        end else begin
            if (state_q == ST_BOOT) begin
                state_d = ST_RUN;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                fifo_pc_d[wr_ptr_q]    = inflight_pc_q;
                fifo_instr_d[wr_ptr_q] = imem_rdata;
                wr_ptr_d               = wr_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
            if (imem_req) begin
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
                pc_d          = pc_q + 32'd4;
            end
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    // Queue storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        fifo_pc_q    <= fifo_pc_d;
        fifo_instr_q <= fifo_instr_d;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: randomized redirects, stalls and resets
// against a queue-based reference model and an in-order stream model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0004;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        fetch_err;

    instr_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    // Reference model: 0 = boot, 1 = run, 2 = trap
    int          m_state;
    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_infl;
    logic [31:0] m_infl_pc;
    bit          m_err;
    bit          m_just_rst;
    logic [31:0] exp_next;

    task automatic cycle();
        bit          pop;
        bit          exp_req;
        bit          mis;
        int          used;
        logic [31:0] tgt;
        logic        req_s;
        logic [31:0] addr_s;

        @(negedge clk);
        pop     = (m_q.size() > 0) && id_ready;
        used    = m_q.size() + int'(m_infl) - int'(pop);
        exp_req = !rst && (m_state == 1) && !redirect_valid && (used < DEPTH);
        if (!rst) begin
            chk("imem_req",  imem_req,  exp_req);
            chk("imem_addr", imem_addr, m_pc);
            chk("if_valid",  if_valid,  m_q.size() > 0);
            chk("fetch_err", fetch_err, m_err);
            if (m_q.size() > 0) begin
                chk("if_pc",    if_pc,    m_q[0][63:32]);
                chk("if_instr", if_instr, m_q[0][31:0]);
            end else if (m_just_rst) begin
                chk("rst_if_pc",    if_pc,    32'h0);
                chk("rst_if_instr", if_instr, 32'h0);
            end
            if (pop && !redirect_valid) begin
                chk("stream_pc",    if_pc,    exp_next);
                chk("stream_instr", if_instr, mem_word(exp_next));
                exp_next += 32'd4;
                n_pops++;
            end
        end
        req_s  = imem_req;
        addr_s = imem_addr;

        @(posedge clk);
        if (rst) begin
            m_state    = 0;
            m_pc       = RST_PC;
            m_q.delete();
            m_infl     = 0;
            m_err      = 0;
            m_just_rst = 1;
            exp_next   = RST_PC;
        end else begin
            m_just_rst = 0;
            if (redirect_valid) begin
                tgt = {redirect_pc[31:2], 2'b00};
                m_q.delete();
                m_infl   = 0;
                m_pc     = tgt;
                exp_next = tgt;
                mis      = 0;
`ifdef IFU_MISALIGN_TRAP_EN
                mis = (redirect_pc[1:0] != 2'b00);
`endif
                if (mis) begin
                    m_err   = 1;
                    m_state = 2;
                end else if (m_state == 0) begin
                    m_state = 1;
                end
            end else begin
                if (pop) void'(m_q.pop_front());
                if (m_infl) m_q.push_back({m_infl_pc, mem_word(m_infl_pc)});
                if (exp_req) begin
                    m_infl    = 1;
                    m_infl_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end else begin
                    m_infl = 0;
                end
                if (m_state == 0) m_state = 1;
            end
        end
        #1;
        imem_rdata = req_s ? mem_word(addr_s) : $urandom();
    endtask

    task automatic run(input int n, input logic rdy);
        id_ready = rdy;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic redir(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        imem_rdata     = 32'h0;
        run(3, 1'b0);
        rst = 1'b0;

        run(10, 1'b1);
        run(6, 1'b0);
        run(6, 1'b1);
        redir(32'h0000_0048);
        run(8, 1'b1);
        redir(32'h0000_0046);
        run(6, 1'b1);
        pulse_rst();
        run(6, 1'b1);
        run(5, 1'b0);
        pulse_rst();
        run(6, 1'b1);
        redir(32'hFFFF_FFF8);
        run(8, 1'b1);
        redir(32'h0000_0100);
        redir(32'h0000_0200);
        run(6, 1'b1);

        for (int i = 0; i < 1500; i++) begin
            id_ready       = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom_range(0, 3) << 2);
                1:       redirect_pc = $urandom() | 32'h1;
                default: redirect_pc = $urandom() & 32'h0000_FFFC;
            endcase
            cycle();
        end
        rst            = 1'b0;
        redirect_valid = 1'b0;
        pulse_rst();
        run(10, 1'b1);

        chk("stream_progress", 32'(n_pops > 100), 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
